joypad_reg: RTL and testbench
=============================

Name: joypad_reg

Overview:
- CPU-side reader of the debounced button signals: the Game Boy P1/JOYP register at 0xFF00.
- Takes eight active-high button levels from the button front-ends and synchronizes them.
- Exposes them to the CPU as the active-low, select-multiplexed P1 nibble.
- Raises a one-cycle joypad interrupt request on any high-to-low transition of the visible nibble.
- Sits between the button front-ends and the CPU bus / interrupt controller.

Parameters:
- REG_ADDR, 16'hFF00, bus address of the P1 register.
- SYNC_STAGES, 2, flip-flop stages per button input synchronizer; minimum 2.

Ports:
- clock  input  1  posedge system clock
- reset  input  1  asynchronous, active-high reset
- btn_right, btn_left, btn_up, btn_down  input  1 each  direction buttons, active-high level
- btn_a, btn_b, btn_select, btn_start  input  1 each  action buttons, active-high level
- addr  input  16  CPU address
- din  input  8  CPU write data
- wr  input  1  write strobe, one cycle per access
- rd  input  1  read strobe
- dout  output  8  read data
- hit  output  1  high when addr == REG_ADDR (combinational)
- int_req  output  1  joypad interrupt request pulse

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clock; all state updates on posedge clock.
- Reset values:
  - sel[1:0] = 2'b11 (nothing selected).
  - All synchronizer flops = 0 (released).
  - nibble_q = 4'hF.
  - int_req = 0.
  - dout = 8'hFF.
- Synchronizers: each btn_* passes through SYNC_STAGES flops; the final stage is btn_s.
- Select register:
  - On a posedge with wr && hit: sel <= din[5:4].
  - Other din bits are ignored.
  - sel[0] = P14 (directions), sel[1] = P15 (actions); 0 = selected.
- nibble_raw, combinational, each bit active-low:
  - dir = ~{down_s, up_s, left_s, right_s}
  - act = ~{start_s, select_s, b_s, a_s}
  - nibble_raw = (sel[0] ? 4'hF : dir) & (sel[1] ? 4'hF : act)
  - Both selected gives the AND of the two groups. Neither selected gives 4'hF.
- Every posedge:
  - nibble_q <= nibble_raw.
  - int_req <= |(nibble_q & ~nibble_raw).
  - int_req is therefore high for exactly one cycle per edge event. Any 1->0 bit transition counts, whether caused by a button or by a sel write. 0->1 transitions never assert it.
- Read path, combinational:
  - dout = {2'b11, sel, nibble_q} when rd && hit, else 8'hFF.
  - Bits 7:6 always read 1.
- Latency (button rising, setup before edge k):
  - btn_s valid after edge k+SYNC_STAGES-1.
  - nibble_q and int_req update at edge k+SYNC_STAGES.
  - With default SYNC_STAGES = 2: a CPU read reflects the press 3 edges after the input changes.
- Simultaneous rd and wr in the same cycle: dout shows the pre-write sel; the new sel appears from the next cycle.
- Write while another bit of the same group is held: the int_req rule still applies per bit; multiple bits falling in one cycle produce a single one-cycle pulse.
- Reset mid-operation: every state returns to its reset value immediately (asynchronous). No int_req is produced by the reset itself or by the first post-reset cycle, because nibble_q = 4'hF and nibble_raw = 4'hF with sel = 11.
- Accesses where addr != REG_ADDR: no state change, dout = 8'hFF, hit = 0.

Test Plan:
- Reset then read 0xFF00 -> dout = 8'hFF, int_req = 0 for 20 cycles with all buttons released.
- Write 8'h20 (select directions), hold btn_up high -> int_req single pulse 2 edges after input change; read returns 8'hEB; no pulse on release.
- Write 8'h10 (select actions), press btn_a and btn_start together -> one int_req pulse; read 8'hD6.
- Hold btn_b with sel = 11, then write 8'h10 -> int_req pulses on the edge after the write; rd+wr in the same cycle returns the old sel (dout 8'hFF).
- Write 8'h00, press btn_right and btn_a -> read 8'hCE (both groups ANDed); then write 8'h30 -> read 8'hFF, no int_req.
- Assert reset while btn_down held and sel = 00 -> outputs at reset values at once; after release, int_req = 0 and sel = 11.

Source files
------------

// File: rtl/joypad_reg_if.sv
// CPU bus bundle for the P1/JOYP register: address, write data, strobes, read data and decode hit.
interface joypad_reg_if;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        wr;
  logic        rd;
  logic [7:0]  dout;
  logic        hit;

  modport master (output addr, din, wr, rd, input dout, hit);
  modport slave  (input addr, din, wr, rd, output dout, hit);
endinterface

// File: rtl/joypad_reg.sv
// Game Boy P1/JOYP register: synchronizes eight button levels, presents the select-multiplexed
// active-low nibble to the CPU and pulses int_req on any visible high-to-low bit transition.
module joypad_reg #(
  parameter logic [15:0] REG_ADDR    = 16'hFF00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           btn_right,
  input  logic           btn_left,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_a,
  input  logic           btn_b,
  input  logic           btn_select,
  input  logic           btn_start,
  joypad_reg_if.slave    bus,
  output logic           int_req
);

  // Bit order: {start, select, b, a, down, up, left, right}
  logic [7:0] btn_vec;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] btn_s;
  logic [1:0] sel_q, sel_d;
  logic [3:0] nibble_q, nibble_d;
  logic       int_req_q, int_req_d;
  logic [3:0] dir, act;
  logic       unused_din;

  assign btn_vec = {btn_start, btn_select, btn_b, btn_a,
                    btn_down, btn_up, btn_left, btn_right};
  assign btn_s   = sync_q[SYNC_STAGES-1];
  assign unused_din = ^{bus.din[7:6], bus.din[3:0]};

  assign bus.hit = (bus.addr == REG_ADDR);

  always_comb begin
    dir       = ~btn_s[3:0];
    act       = ~btn_s[7:4];
    nibble_d  = (sel_q[0] ? 4'hF : dir) & (sel_q[1] ? 4'hF : act);
    int_req_d = |(nibble_q & ~nibble_d);
    sel_d     = sel_q;
    if (bus.wr && bus.hit) begin
      sel_d = bus.din[5:4];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      sel_q     <= 2'b11;
      nibble_q  <= '1;
      int_req_q <= 1'b0;
    end else begin
      sync_q[0] <= btn_vec;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sel_q     <= sel_d;
      nibble_q  <= nibble_d;
      int_req_q <= int_req_d;
    end
  end

  // Read data uses the registered sel, so a same-cycle write is visible only from the next cycle.
  always_comb begin
    bus.dout = 8'hFF;
    if (bus.rd && bus.hit) begin
      bus.dout = {2'b11, sel_q, nibble_q};
    end
  end

  assign int_req = int_req_q;

endmodule

// File: tb/tb_joypad_reg.sv
// Bench for joypad_reg: directed scenarios plus randomized traffic against a history-queue model.
module tb_joypad_reg;
  localparam int unsigned S = 2;

  logic clock = 1'b0;
  logic reset;
  logic btn_right, btn_left, btn_up, btn_down;
  logic btn_a, btn_b, btn_select, btn_start;
  logic int_req;

  joypad_reg_if bus ();

  joypad_reg #(.REG_ADDR(16'hFF00), .SYNC_STAGES(S)) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_right  (btn_right),
    .btn_left   (btn_left),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_a      (btn_a),
    .btn_b      (btn_b),
    .btn_select (btn_select),
    .btn_start  (btn_start),
    .bus        (bus.slave),
    .int_req    (int_req)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: inputs seen at the last S edges, CPU-visible sel, latched nibble, irq.
  logic [7:0] hist [$];
  logic [1:0] sel_m;
  logic [3:0] nib_m;
  logic       int_m;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(S); i++) hist.push_back(8'h00);
    sel_m = 2'b11;
    nib_m = 4'hF;
    int_m = 1'b0;
  endtask

  // One clock edge: the visible nibble uses buttons from S edges ago and the pre-write select.
  task automatic model_edge(input logic [7:0] bv, input logic [15:0] a,
                            input logic [7:0] d, input logic w);
    logic [7:0] bs;
    logic [3:0] vis;
    bs = hist[0];
    for (int i = 0; i < 4; i++) begin
      vis[i] = !((!sel_m[0] && bs[i]) || (!sel_m[1] && bs[4+i]));
    end
    int_m = 1'b0;
    for (int i = 0; i < 4; i++) if (nib_m[i] && !vis[i]) int_m = 1'b1;
    nib_m = vis;
    if (w && a == 16'hFF00) sel_m = d[5:4];
    void'(hist.pop_front());
    hist.push_back(bv);
  endtask

  function automatic logic [7:0] exp_dout(input logic [15:0] a, input logic r);
    return (r && a == 16'hFF00) ? {2'b11, sel_m, nib_m} : 8'hFF;
  endfunction

  // Drive one cycle of inputs at negedge, check combinational/registered outputs, then clock.
  task automatic step(input logic [7:0] bv, input logic [15:0] a, input logic [7:0] d,
                      input logic w, input logic r);
    {btn_start, btn_select, btn_b, btn_a, btn_down, btn_up, btn_left, btn_right} = bv;
    bus.addr = a; bus.din = d; bus.wr = w; bus.rd = r;
    #1;
    check("hit", {7'd0, bus.hit}, {7'd0, a == 16'hFF00});
    check("dout", bus.dout, exp_dout(a, r));
    check("int_req", {7'd0, int_req}, {7'd0, int_m});
    @(posedge clock);
    model_edge(bv, a, d, w);
    @(negedge clock);
  endtask

  logic [7:0] bv_r, din_r;
  logic [15:0] addr_r;
  logic wr_r, rd_r;

  initial begin
    reset = 1'b1;
    {btn_start, btn_select, btn_b, btn_a, btn_down, btn_up, btn_left, btn_right} = '0;
    bus.addr = 16'h0000; bus.din = '0; bus.wr = 1'b0; bus.rd = 1'b0;
    model_reset();
    #1;
    check("reset_irq", {7'd0, int_req}, 8'h00);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // Idle read for 20 cycles
    for (int i = 0; i < 20; i++) step(8'h00, 16'hFF00, 8'h00, 1'b0, 1'b1);

    // Directions selected, press and release up
    step(8'h00, 16'hFF00, 8'h20, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h04, 16'hFF00, 8'h00, 1'b0, 1'b0);
    bus.rd = 1'b1; #1;
    check("read_up", bus.dout, 8'hEB);
    for (int i = 0; i < 5; i++) step(8'h00, 16'hFF00, 8'h00, 1'b0, 1'b1);

    // Actions selected, a+start together
    step(8'h00, 16'hFF00, 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h90, 16'hFF00, 8'h00, 1'b0, 1'b0);
    bus.rd = 1'b1; #1;
    check("read_a_start", bus.dout, 8'hD6);
    for (int i = 0; i < 4; i++) step(8'h00, 16'hFF00, 8'h00, 1'b0, 1'b0);

    // b held with nothing selected, then select actions with rd+wr together
    step(8'h00, 16'hFF00, 8'h30, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h20, 16'hFF00, 8'h00, 1'b0, 1'b0);
    bus.rd = 1'b1; bus.wr = 1'b1; bus.din = 8'h10; #1;
    check("rdwr_old_sel", bus.dout, 8'hFF);
    step(8'h20, 16'hFF00, 8'h10, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h20, 16'hFF00, 8'h00, 1'b0, 1'b1);

    // Both groups selected: right and a ANDed; then deselect both
    step(8'h00, 16'hFF00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h11, 16'hFF00, 8'h00, 1'b0, 1'b0);
    bus.rd = 1'b1; #1;
    check("read_both", bus.dout, 8'hCE);
    step(8'h11, 16'hFF00, 8'h30, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h11, 16'hFF00, 8'h00, 1'b0, 1'b1);

    // Writes and reads to other addresses are ignored
    step(8'h11, 16'hFF01, 8'h00, 1'b1, 1'b1);
    step(8'h11, 16'h7F00, 8'h00, 1'b1, 1'b1);
    step(8'h11, 16'hFF00, 8'h00, 1'b0, 1'b1);

    // Reset mid-operation with down held and both groups selected
    step(8'h08, 16'hFF00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h08, 16'hFF00, 8'h00, 1'b0, 1'b1);
    #2; reset = 1'b1; #1;
    model_reset();
    check("rst_async_dout", bus.dout, 8'hFF);
    check("rst_async_irq", {7'd0, int_req}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(8'h08, 16'hFF00, 8'h00, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bv_r   = 8'($urandom) & 8'($urandom);
      addr_r = ($urandom_range(0, 9) < 8) ? 16'hFF00 : 16'($urandom);
      din_r  = 8'($urandom);
      wr_r   = ($urandom_range(0, 5) == 0);
      rd_r   = 1'($urandom);
      step(bv_r, addr_r, din_r, wr_r, rd_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
